// File: rtl/dump_window_ctrl.sv
// dump_window_ctrl
//   Frame-synchronous capture-window controller for the game test harness.
//   It keeps the canonical frame counter. It opens one independent capture
//   window per channel: immediately, at a programmed frame number, or at the
//   end of a ROM download. It closes the window after a programmed number of
//   frames, where a length of 0 means the window stays open until stop.
//
// Ports
//   clk         system clock (single clock domain)
//   rst         synchronous, active-high reset
//   vs          vertical sync; its falling edge is the frame boundary
//   dwnld       ROM download busy; its falling edge is download end
//   arm         one-cycle pulse; re-arms IDLE or DONE channels
//   stop        one-cycle pulse; forces ARMED/ACTIVE channels to DONE
//   cfg_mode    per channel, 2 bits: 00 off, 01 immediate, 10 frame, 11 download-end
//   cfg_start   per channel, FW bits: trigger frame for mode 10
//   cfg_len     per channel, LW bits: window length in frames (0 = unlimited)
//   frame_cnt   frame counter
//   dump_on     per channel: high while ACTIVE
//   dump_start  per channel: one-cycle strobe on entry to ACTIVE
//   dump_done   per channel: high while DONE

module dump_window_ctrl #(
    parameter int CHANNELS = 2,
    parameter int FW       = 32,
    parameter int LW       = 16,
    parameter int DL_GUARD = 20000,
    parameter int AUTOARM  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vs,
    input  logic                   dwnld,
    input  logic                   arm,
    input  logic                   stop,
    input  logic [2*CHANNELS-1:0]  cfg_mode,
    input  logic [FW*CHANNELS-1:0] cfg_start,
    input  logic [LW*CHANNELS-1:0] cfg_len,
    output logic [FW-1:0]          frame_cnt,
    output logic [CHANNELS-1:0]    dump_on,
    output logic [CHANNELS-1:0]    dump_start,
    output logic [CHANNELS-1:0]    dump_done
);

    localparam int GW = (DL_GUARD < 1) ? 1 : $clog2(DL_GUARD + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ARMED  = 2'b01,
        ST_ACTIVE = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    // Shared control state
    logic          vs_l_q, vs_l_d;
    logic          dl_l_q, dl_l_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic [GW-1:0] guard_q, guard_d;
    logic          init_q;            // set only in the first cycle after reset

    // Per-channel state
    state_t        state_q [CHANNELS];
    state_t        state_d [CHANNELS];
    logic [1:0]    mode_q  [CHANNELS];
    logic [1:0]    mode_d  [CHANNELS];
    logic [FW-1:0] start_q [CHANNELS];
    logic [FW-1:0] start_d [CHANNELS];
    logic [LW-1:0] len_q   [CHANNELS];
    logic [LW-1:0] len_d   [CHANNELS];
    logic [LW-1:0] lcnt_q  [CHANNELS];
    logic [LW-1:0] lcnt_d  [CHANNELS];

    logic [CHANNELS-1:0] trig;
    logic [CHANNELS-1:0] dump_on_q, dump_on_d;
    logic [CHANNELS-1:0] dump_start_q, dump_start_d;
    logic [CHANNELS-1:0] dump_done_q, dump_done_d;

    logic fedge;
    logic dledge_q;                   // download-end edge, qualified by the guard
    logic guard_full;
    logic autoarm_now;

    always_comb begin
        fedge       = vs_l_q & ~vs;
        guard_full  = (guard_q == GW'(DL_GUARD));
        dledge_q    = dl_l_q & ~dwnld & guard_full;
        autoarm_now = (AUTOARM != 0) && init_q;

        vs_l_d      = vs;
        dl_l_d      = dwnld;
        frame_cnt_d = fedge ? (frame_cnt_q + FW'(1)) : frame_cnt_q;
        guard_d     = guard_full ? guard_q : (guard_q + GW'(1));
    end

    // Trigger condition of each armed channel; frame match uses the
    // pre-increment frame count.
    always_comb begin
        trig = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            case (mode_q[i])
                2'b01:   trig[i] = 1'b1;
                2'b10:   trig[i] = fedge && (frame_cnt_q == start_q[i]);
                2'b11:   trig[i] = dledge_q;
                default: trig[i] = 1'b0;
            endcase
        end
    end

    always_comb begin
        dump_on_d    = '0;
        dump_start_d = '0;
        dump_done_d  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            mode_d[i]  = mode_q[i];
            start_d[i] = start_q[i];
            len_d[i]   = len_q[i];
            lcnt_d[i]  = lcnt_q[i];

            // stop always outranks arm, triggers and the length expiry
            case (state_q[i])
                ST_IDLE: begin
                    if (!stop && (arm || autoarm_now) && (cfg_mode[2*i +: 2] != 2'b00)) begin
                        state_d[i] = ST_ARMED;
                        mode_d[i]  = cfg_mode[2*i +: 2];
                        start_d[i] = cfg_start[FW*i +: FW];
                        len_d[i]   = cfg_len[LW*i +: LW];
                    end
                end
                ST_ARMED: begin
                    if (stop) begin
                        state_d[i] = ST_DONE;
                    end else if (trig[i]) begin
                        state_d[i] = ST_ACTIVE;
                        lcnt_d[i]  = '0;
                    end
                end
                ST_ACTIVE: begin
                    if (stop) begin
                        state_d[i] = ST_DONE;
                    end else if (fedge) begin
                        if ((len_q[i] != '0) && ((lcnt_q[i] + LW'(1)) == len_q[i])) begin
                            state_d[i] = ST_DONE;
                        end else begin
                            lcnt_d[i] = lcnt_q[i] + LW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (!stop && arm) begin
                        if (cfg_mode[2*i +: 2] != 2'b00) begin
                            state_d[i] = ST_ARMED;
                            mode_d[i]  = cfg_mode[2*i +: 2];
                            start_d[i] = cfg_start[FW*i +: FW];
                            len_d[i]   = cfg_len[LW*i +: LW];
                        end else begin
                            state_d[i] = ST_IDLE;
                        end
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase

            // Outputs are registered from the next state so they change in the
            // cycle right after the event is sampled.
            dump_on_d[i]    = (state_d[i] == ST_ACTIVE);
            dump_start_d[i] = (state_d[i] == ST_ACTIVE) && (state_q[i] != ST_ACTIVE);
            dump_done_d[i]  = (state_d[i] == ST_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_l_q       <= 1'b1;
            dl_l_q       <= 1'b0;
            frame_cnt_q  <= '0;
            guard_q      <= '0;
            init_q       <= 1'b1;
            dump_on_q    <= '0;
            dump_start_q <= '0;
            dump_done_q  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= ST_IDLE;
                mode_q[i]  <= 2'b00;
            end
        end else begin
            vs_l_q       <= vs_l_d;
            dl_l_q       <= dl_l_d;
            frame_cnt_q  <= frame_cnt_d;
            guard_q      <= guard_d;
            init_q       <= 1'b0;
            dump_on_q    <= dump_on_d;
            dump_start_q <= dump_start_d;
            dump_done_q  <= dump_done_d;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                mode_q[i]  <= mode_d[i];
            end
        end
    end

    // Latched window parameters and the length counter carry no reset; they
    // are only consulted after being loaded on entry to ARMED/ACTIVE.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            start_q[i] <= start_d[i];
            len_q[i]   <= len_d[i];
            lcnt_q[i]  <= lcnt_d[i];
        end
    end

    assign frame_cnt  = frame_cnt_q;
    assign dump_on    = dump_on_q;
    assign dump_start = dump_start_q;
    assign dump_done  = dump_done_q;

endmodule

// File: doc/dump_window_ctrl.md
Name: dump_window_ctrl

Overview:
- Multi-channel, frame-synchronous controller that opens and closes waveform-capture windows. Each window is gated per channel.
- Each channel is triggered immediately, at a programmed frame number, or at the end of a ROM download. The window closes after a programmed number of frames.
- Sits in the game test harness next to the video timing. Its dump_on outputs gate simulation dump/probe logic or an on-chip capture buffer.
- Also keeps the canonical frame counter used by the harness.

Parameters:
- CHANNELS, 2, number of independent capture windows.
- FW, 32, width of the frame counter and of cfg_start fields.
- LW, 16, width of cfg_len fields; a length of 0 means unlimited.
- DL_GUARD, 20000, clk cycles after reset during which download-end triggers are ignored.
- AUTOARM, 1, when 1, channels with a non-zero mode arm themselves in the first cycle after reset.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- vs  in  1  vertical sync, synchronous to clk; the frame boundary is its falling edge.
- dwnld  in  1  ROM download busy; its falling edge marks download end.
- arm  in  1  single-cycle pulse; re-arms idle or done channels.
- stop  in  1  single-cycle pulse; forces armed or active channels to DONE.
- cfg_mode  in  2*CHANNELS  per-channel mode: 00 disabled, 01 immediate, 10 frame trigger, 11 download-end trigger.
- cfg_start  in  FW*CHANNELS  per-channel trigger frame for mode 10.
- cfg_len  in  LW*CHANNELS  per-channel window length in frames.
- frame_cnt  out  FW  frame counter.
- dump_on  out  CHANNELS  high while the channel is ACTIVE.
- dump_start  out  CHANNELS  one-cycle strobe on entry to ACTIVE.
- dump_done  out  CHANNELS  high while the channel is in DONE.

Behaviour:
- The interface is fixed as one clock (clk) with a synchronous, active-high reset (rst).
- Reset values:
  - frame_cnt=0, dump_on=0, dump_start=0, dump_done=0.
  - All channels in IDLE.
  - Edge registers vs_l=1 and dl_l=0.
  - Guard counter=0.
- Edge detection:
  - vs_l and dl_l are registered copies of vs and dwnld.
  - fedge = vs_l & ~vs; dledge = dl_l & ~dwnld.
- Frame counter:
  - On a cycle with fedge, frame_cnt <= frame_cnt+1, wrapping modulo 2^FW.
  - Every comparison uses the pre-increment value.
- Guard counter: counts clk cycles from reset and saturates at DL_GUARD. dledge is qualified only when the guard counter equals DL_GUARD.
- Per-channel FSM, states IDLE, ARMED, ACTIVE, DONE:
  - IDLE -> ARMED on an arm pulse, or on the first cycle after reset when AUTOARM=1, provided cfg_mode!=00.
  - On entry to ARMED, mode, start and len are latched. Later changes to cfg_* do not affect an armed or active channel.
  - ARMED -> ACTIVE:
    - mode 01: on the next clk.
    - mode 10: on fedge with frame_cnt==start.
    - mode 11: on a qualified dledge.
  - ACTIVE:
    - A frame-length counter is cleared on entry and increments on each fedge.
    - With len!=0: on the fedge where counter+1==len, go to DONE. The window therefore spans exactly len frame boundaries.
    - With len==0: remain ACTIVE until stop or reset.
  - DONE -> ARMED on arm, re-latching the current cfg_*. With cfg_mode==00 at that time, go to IDLE instead.
  - stop moves ARMED or ACTIVE to DONE on the next clk. stop has no effect in IDLE or DONE.
- Simultaneous events:
  - stop and arm together: stop wins; arm is ignored that cycle.
  - arm is ignored in ARMED and ACTIVE.
  - A trigger and stop in the same cycle: DONE wins; no dump_start is issued.
  - fedge with counter+1==len coinciding with stop: DONE; identical outcome.
- Output timing:
  - dump_on, dump_start and dump_done are registered from the state.
  - dump_on rises in the cycle after the triggering fedge/dledge is sampled.
  - dump_start is high for exactly that one cycle.
- Reset mid-window: dump_on drops in the cycle after rst is sampled high, and frame_cnt returns to 0.
- Channels are fully independent; they share only frame_cnt, the edge detectors and the guard.

Test Plan:
- Mode 10, start=3, len=2, AUTOARM=1; toggle vs over 8 frames -> dump_start pulses once on the 4th falling edge (pre-increment frame_cnt==3). dump_on stays high for 2 frames, then dump_done=1; frame_cnt=8 at the end.
- Mode 11, DL_GUARD=100; dwnld falls at cycle 50, then again at cycle 300 -> no trigger at cycle 50; dump_on rises at cycle 301.
- Two channels: ch0 mode 01 len=0, ch1 mode 10 start=1 len=1; stop pulsed at frame 5 -> ch0 is active from cycle 1 until stop, then done. ch1 is active during frame 1 only.
- From DONE, change cfg_start to 6 and pulse arm -> the channel re-arms and triggers on the fedge where frame_cnt==6. Changing cfg_start while ARMED has no effect.
- Same-cycle arm+stop in ACTIVE -> DONE, no re-arm. Same-cycle trigger fedge+stop in ARMED -> DONE and dump_start stays 0.
- Assert rst while ACTIVE with frame_cnt=0x10 -> the next cycle shows dump_on=0, dump_done=0, frame_cnt=0. Preload frame_cnt to 2^FW-1 and apply one fedge -> frame_cnt=0.
